// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Four-channel pushbutton synchroniser, debouncer and sticky
//            press-flag generator feeding the processor pushbuttons port.
// Revision : 1.0
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE = 8,
    parameter int STICKY   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       rd_ack,
    output logic [3:0] level,
    output logic [3:0] press_pulse,
    output logic [3:0] pressed
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    logic [3:0] s1;
    logic [3:0] sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1   <= 4'b0000;
            sync <= 4'b0000;
        end else begin
            s1   <= btn_raw;
            sync <= s1;
        end
    end

    generate
        for (genvar ch = 0; ch < 4; ch++) begin : g_chan
            state_t     state;
            state_t     state_nxt;
            logic [7:0] cnt;
            logic [7:0] cnt_nxt;
            logic       level_q;
            logic       level_nxt;
            logic       pulse_q;
            logic       pulse_nxt;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state   <= LOW;
                    cnt     <= 8'd0;
                    level_q <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    state   <= state_nxt;
                    cnt     <= cnt_nxt;
                    level_q <= level_nxt;
                    pulse_q <= pulse_nxt;
                end
            end

            // Any sample disagreeing with the candidate level restarts the count.
            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                level_nxt = level_q;
                pulse_nxt = 1'b0;
                case (state)
                    LOW: begin
                        if (sync[ch]) begin
                            state_nxt = CHK_HI;
                            cnt_nxt   = 8'd1;
                        end
                    end
                    CHK_HI: begin
                        if (!sync[ch]) begin
                            state_nxt = LOW;
                            cnt_nxt   = 8'd0;
                        end else if (cnt == CNT_LAST) begin
                            state_nxt = HIGH;
                            cnt_nxt   = 8'd0;
                            level_nxt = 1'b1;
                            pulse_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 8'd1;
                        end
                    end
                    HIGH: begin
                        if (!sync[ch]) begin
                            state_nxt = CHK_LO;
                            cnt_nxt   = 8'd1;
                        end
                    end
                    CHK_LO: begin
                        if (sync[ch]) begin
                            state_nxt = HIGH;
                            cnt_nxt   = 8'd0;
                        end else if (cnt == CNT_LAST) begin
                            state_nxt = LOW;
                            cnt_nxt   = 8'd0;
                            level_nxt = 1'b0;
                        end else begin
                            cnt_nxt = cnt + 8'd1;
                        end
                    end
                    default: begin
                        state_nxt = LOW;
                        cnt_nxt   = 8'd0;
                        level_nxt = 1'b0;
                    end
                endcase
            end

            assign level[ch]       = level_q;
            assign press_pulse[ch] = pulse_q;
        end
    endgenerate

    generate
        if (STICKY != 0) begin : g_sticky
            logic [3:0] flags;

            // A pulse in the acknowledge cycle survives: the new press wins.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    flags <= 4'b0000;
                end else begin
                    flags <= (flags & ~{4{rd_ack}}) | press_pulse;
                end
            end

            assign pressed = flags;
        end else begin : g_direct
            assign pressed = level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed tables, corner sequences and randomized traffic against
//            a run-length reference model of the button conditioner.
// Revision : 1.0
// ============================================================================
module tb_button_conditioner;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [3:0] btn_raw;
    logic       rd_ack;
    logic [3:0] level;
    logic [3:0] press_pulse;
    logic [3:0] pressed;

    int tests;
    int fails;

    button_conditioner #(.DEBOUNCE(D), .STICKY(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .rd_ack      (rd_ack),
        .level       (level),
        .press_pulse (press_pulse),
        .pressed     (pressed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: raw delayed two cycles, level flips after D consecutive
    // samples that disagree with it.
    logic [3:0] m_d1, m_d2, m_lvl, m_pulse, m_prs;
    int         m_run [4];

    function automatic void model_reset();
        m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pulse = '0; m_prs = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input logic a);
        logic [3:0] n_lvl, n_pulse;
        n_lvl   = m_lvl;
        n_pulse = '0;
        m_prs   = a ? m_pulse : (m_prs | m_pulse);
        for (int i = 0; i < 4; i++) begin
            if (m_d2[i] != m_lvl[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == D) begin
                    n_lvl[i]   = ~m_lvl[i];
                    n_pulse[i] = ~m_lvl[i];
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_lvl   = n_lvl;
        m_pulse = n_pulse;
        m_d2    = m_d1;
        m_d1    = r;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: {level,pulse,pressed} got %b_%b_%b expected %b_%b_%b",
                     name, act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic a);
        @(negedge clock);
        btn_raw = r;
        rd_ack  = a;
        @(posedge clock);
        model_edge(r, a);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rd_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] raw;
        logic       ack;
        logic [3:0] lv;
        logic [3:0] pp;
        logic [3:0] pr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tests   = 0;
        fails   = 0;
        btn_raw = 4'b0000;
        rd_ack  = 1'b0;
        reset   = 1'b0;

        // Clean press then acknowledge: pulse after edge 6, flag after edge 7.
        tbl[0] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[2] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[3] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[4] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[5] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000};
        tbl[6] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0001};
        tbl[7] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0001};
        tbl[8] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        tbl[9] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000};

        apply_reset();
        check("reset_state", {level, press_pulse, pressed}, 12'h000);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].raw, tbl[i].ack);
            check($sformatf("clean_press_row%0d", i), {level, press_pulse, pressed},
                  {tbl[i].lv, tbl[i].pp, tbl[i].pr});
        end

        // Glitch: three cycles high on channel 1 is rejected.
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            step((i < 3) ? 4'b0010 : 4'b0000, 1'b0);
            check($sformatf("glitch_cyc%0d", i), {level, press_pulse, pressed}, 12'h000);
        end

        // Acknowledge clears both flags, level untouched.
        apply_reset();
        for (int i = 0; i < 8; i++) step(4'b0101, 1'b0);
        check("ack_before", {level, press_pulse, pressed}, {4'b0101, 4'b0000, 4'b0101});
        step(4'b0101, 1'b1);
        check("ack_clear", {level, press_pulse, pressed}, {4'b0101, 4'b0000, 4'b0000});
        step(4'b0101, 1'b0);
        check("ack_after", {level, press_pulse, pressed}, {4'b0101, 4'b0000, 4'b0000});

        // Simultaneous set/clear: ack in the cycle press_pulse[2] is high.
        apply_reset();
        for (int i = 0; i < 8; i++) step(4'b0001, 1'b0);
        check("simul_pre", {level, press_pulse, pressed}, {4'b0001, 4'b0000, 4'b0001});
        for (int i = 0; i < 5; i++) step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        check("simul_pulse", {level, press_pulse, pressed}, {4'b0101, 4'b0100, 4'b0001});
        step(4'b0101, 1'b1);
        check("simul_result", {level, press_pulse, pressed}, {4'b0101, 4'b0000, 4'b0100});

        // Bounce on release: sync settles low after edge 8, level falls at edge 12.
        apply_reset();
        for (int i = 0; i < 8; i++) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            logic [3:0] r;
            r = (i <= 6 && (i % 2 == 0)) ? 4'b0001 : 4'b0000;
            step(r, 1'b0);
            check($sformatf("bounce_edge%0d", i), {level, press_pulse, pressed},
                  {(i < 12) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000});
        end

        // Reset in the middle of CHK_HI with the button held.
        apply_reset();
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0);
        #2 reset = 1'b1;
        #1 check("midreset_async", {level, press_pulse, pressed}, 12'h000);
        model_reset();
        repeat (2) @(posedge clock);
        #1 check("midreset_held", {level, press_pulse, pressed}, 12'h000);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(4'b0001, 1'b0);
            check($sformatf("midreset_edge%0d", i), {level, press_pulse, pressed},
                  {(i >= 6) ? 4'b0001 : 4'b0000, (i == 6) ? 4'b0001 : 4'b0000,
                   (i == 7) ? 4'b0001 : 4'b0000});
        end

        // Randomized traffic against the reference model.
        apply_reset();
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int i = 0; i < 1500; i++) begin
                for (int c = 0; c < 4; c++)
                    if ($urandom_range(5) == 0) r[c] = ~r[c];
                step(r, ($urandom_range(7) == 0));
                check($sformatf("random_cyc%0d", i), {level, press_pulse, pressed},
                      {m_lvl, m_pulse, m_prs});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Four-channel pushbutton front end that sits directly upstream of the processor's `pushbuttons[3:0]` input buffer. Each raw, asynchronous button line is synchronised, debounced by a per-channel state machine, and turned into a sticky "pressed" flag. The flag holds until the processor acknowledges it by reading the input port, so a press shorter than an instruction fetch/execute pair is never lost.

## Interface
Parameters:
- `DEBOUNCE`, default 8: consecutive stable synchronised cycles required to accept a level change. Legal range is 2..255; the counter is 8 bits.
- `STICKY`, default 1: 1 drives `pressed` from the latched flags; 0 drives `pressed` straight from `level`.

Ports:
- `clock` in 1: system clock, the same clock as the processor.
- `reset` in 1: asynchronous, active-high.
- `btn_raw` in 4: raw button lines, asynchronous, active-high.
- `rd_ack` in 1: one-cycle acknowledge, driven by the processor's input-read enable (`oeIN`) during its execute phase.
- `level` out 4: debounced button level.
- `press_pulse` out 4: one-cycle strobe on each accepted rising edge of `level`.
- `pressed` out 4: flags presented to the processor `pushbuttons` port.

## Operation
- **Synchroniser.** Two flip-flops per channel, `s1` then `s2`. Only `s2` (called `sync`) feeds downstream logic.
- **Debounce FSM, per channel.** States are `LOW`, `CHK_HI`, `HIGH`, `CHK_LO`. Each channel has an 8-bit counter `cnt`.
  - `LOW`: `level=0`, `cnt=0`. If `sync=1`, go to `CHK_HI`, `cnt<=1`.
  - `CHK_HI`: if `sync=0`, go to `LOW`, `cnt<=0` (glitch rejected).
    - Else if `cnt==DEBOUNCE-1`, go to `HIGH`, `level<=1`, `press_pulse<=1`, `cnt<=0`.
    - Else `cnt<=cnt+1`.
  - `HIGH` and `CHK_LO`: mirror images of `LOW` and `CHK_HI`. Release never produces a pulse.
- **Counter width.** `cnt` never exceeds `DEBOUNCE-1`, so it has no wrap-around.
- **Sticky flags** (`STICKY=1`), per channel:
  - Set on `press_pulse`.
  - Cleared on `rd_ack`.
  - If `rd_ack` and `press_pulse` occur in the same cycle, the flag ends at 1 (the new press wins).
  - `rd_ack` clears all four flags together; a channel already at 0 is unaffected.
- **Register type.** `press_pulse`, `level` and `pressed` are all registered outputs. There are no combinational paths from `btn_raw` or `rd_ack` to any output.
- **Channel independence.** All four channels run fully independently; simultaneous presses are all captured.

## Timing
- **Reset values.** `level=0`, `press_pulse=0`, `pressed=0`. `s1`, `s2` and all `cnt` are 0, and every FSM is in `LOW`.
- **Latency.** Take a raw change set up before edge 1 and held steady.
  - `sync` changes after edge 2.
  - `level` and `press_pulse` assert after edge `2+DEBOUNCE`.
  - `pressed` asserts one edge later, at `3+DEBOUNCE`.
- **Pulse width.** `press_pulse` is high for exactly one clock cycle per accepted press.
- **Glitch rejection.** A `sync` excursion shorter than `DEBOUNCE` cycles never changes `level`.
- **Acknowledge.** `pressed` falls on the edge after `rd_ack` is sampled high.
  - Holding `rd_ack` high for several cycles is legal and keeps the flags clear.
  - A press completing during that window is set on the same cycle as its pulse.
- **Reset mid-operation.** Everything clears immediately; any partial debounce count is discarded.
  - If a button is held through reset release, it is treated as a fresh press.
  - In that case `level` and `press_pulse` assert after edge `2+DEBOUNCE` following release.

## Test plan
All scenarios use `DEBOUNCE=4` and `STICKY=1`.
- **Clean press.** `btn_raw=4'b0001` held before edge 1 -> `level[0]=1` and a single `press_pulse[0]` after edge 6; `pressed=4'b0001` after edge 7.
- **Glitch.** `btn_raw[1]` high for exactly 3 cycles -> `level`, `press_pulse` and `pressed` stay `4'b0000` throughout.
- **Acknowledge.** Starting from `pressed=4'b0101`, one-cycle `rd_ack` -> `pressed=4'b0000` on the next edge; `level` is unchanged.
- **Simultaneous set/clear.** `rd_ack` coincides with `press_pulse[2]` while `pressed=4'b0001` -> `pressed=4'b0100`.
- **Bounce on release.** Button released with alternating 1-cycle bounces for 6 cycles, then held low -> `level` falls exactly 4 cycles after `sync` settles low; no extra `press_pulse`.
- **Reset mid-operation.** Assert `reset` during `CHK_HI` with the button held, then release -> all outputs 0 during reset; `press_pulse[0]` fires after edge 6 counted from release.
